// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-input round-robin pick; on a tie the port that did not win last time is chosen
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic  a_req,
    input  logic  b_req,
    input  port_t last_winner,
    output logic  grant_valid,
    output port_t grant_id
);
    // single requester wins outright, a tie goes to the port that is not last_winner
    always_comb begin
        grant_valid = a_req | b_req;
        grant_id    = (a_req && b_req) ? ((last_winner == PORT_A) ? PORT_B : PORT_A)
                                       : (b_req ? PORT_B : PORT_A);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between ports A and B; optional bounds check via DMEM_ARB_BOUNDS_CHK_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_load,
    output logic              mem_store,
    input  logic [DATA_W-1:0] mem_dataout
);
    state_t            state, state_n;
    port_t             last_winner, owner, grant_id;
    logic              grant_valid, l_we, in_range;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;

    dmem_rr_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_winner (last_winner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef DMEM_ARB_BOUNDS_CHK_EN
    logic l_oor;
    // remember whether the granted address lies beyond the implemented words
    always_ff @(posedge clk or posedge rst)
        if (rst)
            l_oor <= 1'b0;
        else if (state == IDLE && grant_valid)
            l_oor <= ((grant_id == PORT_B) ? b_addr : a_addr) >= ADDR_W'(MEM_DEPTH);
    assign in_range = !l_oor;
    assign a_err    = a_ack & l_oor;
    assign b_err    = b_ack & l_oor;
`else
    assign in_range = 1'b1;
    assign a_err    = 1'b0;
    assign b_err    = 1'b0;
`endif

    // state register, grant latch and per-port read-data capture
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            last_winner <= PORT_B;
            owner       <= PORT_A;
            l_we        <= 1'b0;
            l_addr      <= '0;
            l_wdata     <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && grant_valid) begin
                owner       <= grant_id;
                last_winner <= grant_id;
                l_we        <= (grant_id == PORT_B) ? b_we : a_we;
                l_addr      <= (grant_id == PORT_B) ? b_addr : a_addr;
                l_wdata     <= (grant_id == PORT_B) ? b_wdata : a_wdata;
            end
            if (mem_load && owner == PORT_A)
                a_rdata <= mem_dataout;
            if (mem_load && owner == PORT_B)
                b_rdata <= mem_dataout;
        end

    // IDLE -> ACCESS on a grant, ACCESS -> DONE -> IDLE unconditionally
    always_comb begin
        state_n = (state == IDLE) ? (grant_valid ? ACCESS : IDLE)
                                  : ((state == ACCESS) ? DONE : IDLE);
    end

    // memory strobes only in ACCESS; acks only in DONE for the owner
    always_comb begin
        mem_load  = (state == ACCESS) && !l_we && in_range;
        mem_store = (state == ACCESS) && l_we && in_range;
        a_ack     = (state == DONE) && (owner == PORT_A);
        b_ack     = (state == DONE) && (owner == PORT_B);
    end

    assign mem_address = l_addr;
    assign mem_datain  = l_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
`ifdef DMEM_ARB_BOUNDS_CHK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [7:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_ack, b_ack, a_err, b_err, mem_load, mem_store;
    logic [15:0] a_rdata, b_rdata, mem_datain, mem_dataout;
    logic [7:0]  mem_address;
    logic [15:0] mem [256];
    int          checks = 0, failures = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_address(mem_address), .mem_datain(mem_datain),
        .mem_load(mem_load), .mem_store(mem_store), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_address];

    always @(posedge clk)
        if (mem_store) mem[mem_address] <= mem_datain;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0111);
        #1;
        check("rst_store_async", 32'(mem_store), 0);
        step();
        check("rst_store_c1", 32'(mem_store), 0);
        step();
        check("rst_strobes", 32'({a_ack, b_ack, a_err, b_err, mem_load, mem_store}), 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_mem_bus", {8'h0, mem_address, mem_datain}, 0);
        rst = 0;
        // port A store 3 <- BEEF
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 16'hBEEF;
        step();
        check("st_access", 32'({mem_store, mem_load, a_ack}), 32'b100);
        check("st_bus", {8'h0, mem_address, mem_datain}, {16'h0003, 16'hBEEF});
        step();
        check("st_ack", 32'({a_ack, b_ack, mem_store}), 32'b100);
        a_req = 0;
        step();
        check("st_idle", 32'({a_ack, mem_store}), 0);
        check("st_hold_bus", {8'h0, mem_address, mem_datain}, {16'h0003, 16'hBEEF});
        check("st_mem", 32'(mem[3]), 32'hBEEF);
        // port A load 3
        a_req = 1; a_we = 0;
        step();
        check("ld_access", 32'({mem_load, mem_store, a_ack}), 32'b100);
        step();
        check("ld_ack", 32'({a_ack, b_ack}), 32'b10);
        check("ld_rdata", 32'(a_rdata), 32'hBEEF);
        a_req = 0;
        step();
        // fresh reset so A wins the first tie
        rst = 1;
        step();
        rst = 0;
        a_req = 1; a_we = 0; a_addr = 1;
        b_req = 1; b_we = 0; b_addr = 2;
        step();
        check("tie_a_addr", 32'(mem_address), 1);
        step();
        check("tie_a_ack", 32'({a_ack, b_ack}), 32'b10);
        check("tie_a_rdata", 32'(a_rdata), 32'h0111);
        step();
        check("tie_gap", 32'({a_ack, b_ack}), 0);
        step();
        check("tie_b_addr", 32'({mem_address, 7'h0, mem_load}), {8'd2, 8'h01});
        step();
        check("tie_b_ack", 32'({a_ack, b_ack}), 32'b01);
        check("tie_b_rdata", 32'(b_rdata), 32'h0222);
        step();
        step();
        check("tie_a2_addr", 32'(mem_address), 1);
        step();
        check("tie_a2_ack", 32'({a_ack, b_ack}), 32'b10);
        a_req = 0; b_req = 0;
        step();
        // request change after grant
        a_req = 1; a_we = 0; a_addr = 5;
        step();
        a_addr = 7;
        #1;
        check("chg_addr", 32'(mem_address), 5);
        step();
        check("chg_rdata", 32'({15'h0, a_ack, a_rdata}), {16'h0001, 16'h0555});
        a_req = 0;
        step();
        // reset during a B store
        b_req = 1; b_we = 1; b_addr = 4; b_wdata = 16'h1234;
        step();
        check("rs_store_on", 32'(mem_store), 1);
        #2 rst = 1;
        #1;
        check("rs_store_drop", 32'(mem_store), 0);
        step();
        check("rs_no_ack", 32'(b_ack), 0);
        rst = 0; b_req = 0;
        step();
        check("rs_no_ack2", 32'(b_ack), 0);
        b_req = 1; b_we = 0; b_addr = 4;
        step();
        step();
        check("rs_old_val", 32'({15'h0, b_ack, b_rdata}), {16'h0001, 16'h0444});
        b_req = 0;
        step();
        // A load 3, then out-of-range store 12 must leave a_rdata alone
        a_req = 1; a_we = 0; a_addr = 3;
        step();
        step();
        check("pre_bc_rdata", 32'(a_rdata), 32'hBEEF);
        a_req = 0;
        step();
        a_req = 1; a_we = 1; a_addr = 12; a_wdata = 16'hDEAD;
        step();
        check("bc_store", 32'(mem_store), 32'(!BC));
        step();
        check("bc_ack_err", 32'({a_ack, a_err, b_err}), {29'h0, 1'b1, BC, 1'b0});
        check("bc_rdata_kept", 32'(a_rdata), 32'hBEEF);
        a_req = 0;
        step();
        check("bc_err_clear", 32'({a_ack, a_err}), 0);
        check("bc_mem12", 32'(mem[12]), BC ? 32'h0CCC : 32'hDEAD);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 16-bit data memory. It shares the single memory port between the processor load/store unit (port A) and a secondary master such as a DMA or debug loader (port B). It drives the memory's address, data, load and store lines from one latched request at a time, and returns registered read data with a one-cycle acknowledge. It sits between the execute stage and the data memory.

## Interface
Parameters:
- ADDR_W, 8: address width, matching the memory address port.
- DATA_W, 16: data width.
- MEM_DEPTH, 10: number of implemented memory words; used only by the bounds check.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- a_req / b_req  in  1  access request; held high until the matching ack.
- a_we / b_we  in  1  1 = store, 0 = load; sampled with req.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  DATA_W  store data.
- a_ack / b_ack  out  1  one-cycle pulse: access complete.
- a_rdata / b_rdata  out  DATA_W  load result; valid while the matching ack is high, held afterwards.
- a_err / b_err  out  1  out-of-range flag, qualified by ack (bounds-check builds only; tied 0 otherwise).
- mem_address  out  ADDR_W  to memory address.
- mem_datain  out  DATA_W  to memory datain.
- mem_load / mem_store  out  1  to memory load/store.
- mem_dataout  in  DATA_W  from memory dataout (combinational read).

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:** if any req is high, pick a winner and latch its we, addr and wdata into internal registers, then go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:** round-robin on a last_winner bit.
  - Single requester wins unconditionally.
  - When both request, the port that is not last_winner wins.
  - last_winner updates only when a grant is taken.
- **ACCESS:** mem_address = latched addr.
  - Store: mem_datain = latched wdata, mem_store = 1.
  - Load: mem_load = 1.
  - At the closing edge the memory write occurs. For a load, mem_dataout is captured into the winner's rdata register.
  - Then go to DONE.
- **DONE:** assert the winner's ack for exactly this cycle. Go to IDLE. Requests are not sampled in DONE.
- **Requester rule:** drop req in the cycle after ack unless a new access is wanted. A req still high in IDLE is treated as a new request.
- **Outside ACCESS:** mem_load = mem_store = 0. mem_address and mem_datain hold their latched values (no glitching to 0).
- A store leaves that port's rdata unchanged.
- The loser's req is not disturbed. It is served in the next IDLE.

## Timing
- **Reset values:** state = IDLE, last_winner = B (so A wins the first tie); all ack and err = 0; rdata = 0; mem_* = 0.
- **Latency:** req high at edge N → ACCESS in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles with back-to-back requests.
- **Both ports held:** order A, B, A, B…; each completes within 6 cycles of request.
- **Reset during ACCESS:** mem_store drops immediately (asynchronous) and no write or ack occurs. The request is lost; the requester must re-issue it.
- **Request changes:** req/we/addr/wdata changing after the grant edge have no effect on the access in flight.

## Configuration
- Macro: DMEM_ARB_BOUNDS_CHK_EN.
- **Defined:** a latched addr ≥ MEM_DEPTH still passes through ACCESS, but mem_load and mem_store stay 0. rdata is unchanged. err is asserted together with ack in DONE.
- **Undefined:** no comparison is made. Every address is forwarded, and err outputs are constant 0.

## Structure
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the port-id type (PORT_A, PORT_B);
  - ADDR_W/DATA_W defaults.
- Sub-module dmem_rr_pick: combinational two-input round-robin pick from (a_req, b_req, last_winner) giving grant_valid and grant_id. The FSM and latches stay in the top.

## Test plan
- **Reset:** assert rst for 2 cycles → all outputs 0, state IDLE; mem_store never rises.
- **Port A store then load:** A store addr 3, data 16'hBEEF → a_ack at N+2; then A load addr 3 → a_rdata = 16'hBEEF with a_ack; b_ack stays 0.
- **Simultaneous requests:** A load addr 1 and B load addr 2, held → A acks first, then B (ack cycles 3 apart), then A again if still held; memory-init value 16'h0111 returned.
- **Request change after grant:** change a_addr from 5 to 7 during ACCESS → access uses 5.
- **Reset in ACCESS:** B store addr 4, data 16'h1234; rst pulsed during ACCESS → no b_ack; later load addr 4 returns the old value.
- **Bounds check (macro defined):** A store addr 12 → a_ack with a_err = 1, mem_store never high. Without the macro, a_err = 0 and mem_store pulses.
